// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
//   uart_feed_state_t          : feeder FSM states
//   UART_FEED_BUSY_TIMEOUT     : cycles the feeder waits for busy to rise
//   UART_TX_FIFO_DEPTH_DEFAULT : default transmit FIFO depth
package uart_pkg;

  typedef enum logic [1:0] {
    F_IDLE      = 2'd0,
    F_ISSUE     = 2'd1,
    F_WAIT_BUSY = 2'd2,
    F_WAIT_DONE = 2'd3
  } uart_feed_state_t;

  localparam int unsigned UART_FEED_BUSY_TIMEOUT     = 4;
  localparam int unsigned UART_FEED_TMO_W            = $clog2(UART_FEED_BUSY_TIMEOUT);
  localparam int unsigned UART_TX_FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and an up/down occupancy counter.
//   clk, rst   : clock, synchronous active-high reset
//   push       : enqueue push_data (accepted if not full, or full with a same-cycle pop)
//   pop        : dequeue head (ignored while empty)
//   pop_data   : current head entry
//   flush      : empty the FIFO; overrides push and pop
//   full/empty : registered occupancy flags
//   count      : entries currently queued
module sync_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   pop_data,
  input  logic                    flush,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_nxt_c;
  logic                  full_q;
  logic                  empty_q;
  logic                  do_pop_c;
  logic                  do_push_c;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop_c  = pop & ~empty_q & ~flush;
  assign do_push_c = push & (~full_q | do_pop_c) & ~flush;

  // Occupancy next-state.
  always_comb begin
    count_nxt_c = count_q;
    if (flush) begin
      count_nxt_c = '0;
    end else if (do_push_c && !do_pop_c) begin
      count_nxt_c = count_q + CNT_W'(1);
    end else if (!do_push_c && do_pop_c) begin
      count_nxt_c = count_q - CNT_W'(1);
    end
  end

  // Pointers, counter and flags; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_nxt_c;
      full_q  <= (count_nxt_c == CNT_W'(DEPTH));
      empty_q <= (count_nxt_c == '0);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer plus feeder that hands bytes one at a time to the UART transmitter.
//   clk, rst           : clock, synchronous active-high reset
//   wr_en_i/wr_data_i  : push a byte
//   flush_i            : discard queued bytes (in-flight byte completes)
//   clr_overflow_i     : clear sticky overflow_o
//   full_o/empty_o     : FIFO flags; count_o bytes queued
//   overflow_o         : sticky, a push was dropped while full
//   idle_o             : nothing queued, feeder idle, transmitter not busy
//   uart_tx_en_o       : one-cycle start pulse; uart_tx_data_o holds the byte
//   uart_tx_busy_i     : transmitter busy flag
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = UART_TX_FIFO_DEPTH_DEFAULT,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    flush_i,
  input  logic                    clr_overflow_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o,
  output logic                    idle_o,
  output logic                    uart_tx_en_o,
  output logic [DATA_WIDTH-1:0]   uart_tx_data_o,
  input  logic                    uart_tx_busy_i
);

  localparam int unsigned TMO_W = UART_FEED_TMO_W;

  uart_feed_state_t      state_q, state_nxt;
  logic                  en_q, en_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic [TMO_W-1:0]      tmo_q, tmo_nxt;
  logic                  ovf_q, ovf_nxt;
  logic                  pop_c;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;

  sync_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en_i),
    .push_data (wr_data_i),
    .pop       (pop_c),
    .pop_data  (fifo_rdata),
    .flush     (flush_i),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count_o)
  );

  // Feeder next-state, pop strobe and sticky overflow.
  always_comb begin
    state_nxt = state_q;
    en_nxt    = 1'b0;
    data_nxt  = data_q;
    tmo_nxt   = tmo_q;
    pop_c     = 1'b0;
    ovf_nxt   = ovf_q;

    case (state_q)
      F_IDLE: begin
        // A flushing FIFO does not hand out its head.
        if (!fifo_empty && !uart_tx_busy_i && !flush_i) begin
          pop_c     = 1'b1;
          data_nxt  = fifo_rdata;
          en_nxt    = 1'b1;
          state_nxt = F_ISSUE;
        end
      end
      F_ISSUE: begin
        tmo_nxt   = '0;
        state_nxt = F_WAIT_BUSY;
      end
      F_WAIT_BUSY: begin
        // A transmitter that never answers costs the byte, not the stream.
        if (uart_tx_busy_i) begin
          state_nxt = F_WAIT_DONE;
        end else if (tmo_q == TMO_W'(UART_FEED_BUSY_TIMEOUT - 1)) begin
          state_nxt = F_IDLE;
        end else begin
          tmo_nxt = tmo_q + TMO_W'(1);
        end
      end
      F_WAIT_DONE: begin
        if (!uart_tx_busy_i) state_nxt = F_IDLE;
      end
      default: state_nxt = F_IDLE;
    endcase

    // Set beats clear when both happen in the same cycle.
    if (clr_overflow_i) ovf_nxt = 1'b0;
    if (wr_en_i && fifo_full && !pop_c && !flush_i) ovf_nxt = 1'b1;
  end

  // Feeder registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= F_IDLE;
      en_q    <= 1'b0;
      data_q  <= '0;
      tmo_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      en_q    <= en_nxt;
      data_q  <= data_nxt;
      tmo_q   <= tmo_nxt;
      ovf_q   <= ovf_nxt;
    end
  end

  assign full_o         = fifo_full;
  assign empty_o        = fifo_empty;
  assign overflow_o     = ovf_q;
  assign uart_tx_en_o   = en_q;
  assign uart_tx_data_o = data_q;
  assign idle_o         = fifo_empty & (state_q == F_IDLE) & ~uart_tx_busy_i;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: behavioural transmitter, byte scoreboard, vector table.
module tb_uart_tx_fifo;

  localparam int unsigned TX_CYCLES = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       flush_i = 1'b0;
  logic       clr_overflow_i = 1'b0;
  logic       full_o, empty_o, overflow_o, idle_o, uart_tx_en_o;
  logic [4:0] count_o;
  logic [7:0] uart_tx_data_o;
  logic       uart_tx_busy_i;

  logic       busy_q = 1'b0;
  int         bt = 0;
  logic       hold_busy = 1'b0;
  logic       mute = 1'b0;
  int         pulses = 0;
  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       fl;
    logic       clr;
    int         cnt;
    logic       full;
    logic       ovf;
  } vec_t;
  vec_t tbl[22];

  always #5 clk = ~clk;

  assign uart_tx_busy_i = busy_q | hold_busy;

  uart_tx_fifo dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en_i        (wr_en_i),
    .wr_data_i      (wr_data_i),
    .flush_i        (flush_i),
    .clr_overflow_i (clr_overflow_i),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .idle_o         (idle_o),
    .uart_tx_en_o   (uart_tx_en_o),
    .uart_tx_data_o (uart_tx_data_o),
    .uart_tx_busy_i (uart_tx_busy_i)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: busy rises the cycle after en and stays up TX_CYCLES.
  always @(posedge clk) begin
    if (uart_tx_en_o) begin
      pulses++;
      if (!mute) chk("busy_low_at_pulse", int'(busy_q), 0);
      chk("pulse_expected", int'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("tx_byte", int'(uart_tx_data_o), int'(sb.pop_front()));
      if (!mute) begin
        busy_q <= 1'b1;
        bt     <= TX_CYCLES;
      end
    end else if (bt > 0) begin
      bt <= bt - 1;
      if (bt == 1) busy_q <= 1'b0;
    end
  end

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (!idle_o && k < 2000) begin
      tick();
      k++;
    end
    chk({nm, "_idle"}, int'(idle_o), 1);
    chk({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic push(input logic [7:0] d, input logic expect_tx);
    wr_en_i   = 1'b1;
    wr_data_i = d;
    if (expect_tx) sb.push_back(d);
    tick();
    wr_en_i   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;

    for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, i + 1, (i == 15), 1'b0};
    tbl[16] = '{1'b1, 8'hAA, 1'b0, 1'b0, 16, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 16, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 8'hCC, 1'b0, 1'b1, 16, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 16, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 16, 1'b1, 1'b0};
    tbl[21] = '{1'b1, 8'hDD, 1'b1, 1'b0, 0, 1'b0, 1'b0};

    // Reset then idle
    rst = 1'b1;
    tick();
    tick();
    chk("rst_empty", int'(empty_o), 1);
    chk("rst_count", int'(count_o), 0);
    chk("rst_en", int'(uart_tx_en_o), 0);
    chk("rst_idle", int'(idle_o), 1);
    chk("rst_ovf", int'(overflow_o), 0);
    chk("rst_data", int'(uart_tx_data_o), 0);
    rst = 1'b0;
    tick();

    // Single byte latency
    p0 = pulses;
    push(8'h55, 1'b1);
    chk("e0_count", int'(count_o), 1);
    chk("e0_en", int'(uart_tx_en_o), 0);
    tick();
    chk("e1_en", int'(uart_tx_en_o), 1);
    chk("e1_data", int'(uart_tx_data_o), 8'h55);
    chk("e1_count", int'(count_o), 0);
    tick();
    chk("e2_en", int'(uart_tx_en_o), 0);
    chk("e2_data", int'(uart_tx_data_o), 8'h55);
    drain("single");
    chk("single_pulses", pulses - p0, 1);

    // Burst of 16; one byte already popped after the last push
    p0 = pulses;
    for (int i = 0; i < 16; i++) push(8'(i + 1), 1'b1);
    chk("burst_count", int'(count_o), 15);
    chk("burst_full", int'(full_o), 0);
    drain("burst");
    chk("burst_pulses", pulses - p0, 16);

    // Overflow / clear / flush table with the transmitter held busy
    hold_busy = 1'b1;
    for (int i = 0; i < 22; i++) begin
      wr_en_i        = tbl[i].wr;
      wr_data_i      = tbl[i].d;
      flush_i        = tbl[i].fl;
      clr_overflow_i = tbl[i].clr;
      tick();
      wr_en_i        = 1'b0;
      flush_i        = 1'b0;
      clr_overflow_i = 1'b0;
      chk($sformatf("vec%0d_count", i), int'(count_o), tbl[i].cnt);
      chk($sformatf("vec%0d_full", i), int'(full_o), int'(tbl[i].full));
      chk($sformatf("vec%0d_empty", i), int'(empty_o), int'(tbl[i].cnt == 0));
      chk($sformatf("vec%0d_ovf", i), int'(overflow_o), int'(tbl[i].ovf));
    end
    hold_busy = 1'b0;
    tick();
    chk("tbl_no_pulse", int'(uart_tx_en_o), 0);

    // Full FIFO: push coincident with the feeder pop
    p0 = pulses;
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b1);
    chk("pp_full_before", int'(full_o), 1);
    hold_busy = 1'b0;
    push(8'hBB, 1'b1);
    chk("pp_count", int'(count_o), 16);
    chk("pp_ovf", int'(overflow_o), 0);
    chk("pp_en", int'(uart_tx_en_o), 1);
    drain("pushpop");
    chk("pp_pulses", pulses - p0, 17);

    // Busy never rises: each byte times out, no retry
    p0 = pulses;
    mute = 1'b1;
    push(8'h77, 1'b1);
    push(8'h78, 1'b1);
    drain("timeout");
    chk("timeout_pulses", pulses - p0, 2);
    mute = 1'b0;
    tick();

    // Flush while the first byte is in flight
    p0 = pulses;
    push(8'h61, 1'b1);
    for (int i = 1; i < 5; i++) push(8'(8'h61 + i), 1'b0);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_count", int'(count_o), 0);
    chk("flush_empty", int'(empty_o), 1);
    drain("flush");
    chk("flush_pulses", pulses - p0, 1);

    // Reset while the first byte is in flight
    p0 = pulses;
    push(8'h71, 1'b1);
    for (int i = 1; i < 5; i++) push(8'(8'h71 + i), 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_en", int'(uart_tx_en_o), 0);
    chk("rst2_count", int'(count_o), 0);
    chk("rst2_empty", int'(empty_o), 1);
    chk("rst2_busy_kept", int'(uart_tx_busy_i), 1);
    drain("rst2");
    chk("rst2_pulses", pulses - p0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
